camera_reg_if_mc: RTL and testbench

- Multi-channel, parametrised configuration register bank for the parallel camera uDMA peripheral.
- Provides N_CH RX channel descriptors and a double-buffered (staging/active) camera configuration set, committed atomically at a frame boundary.
- Adds a sticky W1C event status register, an interrupt mask and a registered interrupt output.
- Sits between the uDMA configuration bus and the camera IP / RX channel logic.

---
 rtl/camera_reg_if_mc_pkg.sv | 36 +++
 rtl/camera_reg_if_mc_if.sv | 14 +
 rtl/camera_rx_ch_regs.sv | 76 +++++++
 rtl/camera_reg_if_mc.sv | 166 ++++++++++++++++
 tb/tb_camera_reg_if_mc.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/camera_reg_if_mc_pkg.sv
// Shared constants, commit FSM states and camera config set type for the camera register bank.
package camera_reg_pkg;

    // Word offsets inside one 4-word channel descriptor
    localparam int unsigned ChWordSaddr   = 0;
    localparam int unsigned ChWordSize    = 1;
    localparam int unsigned ChWordCfg     = 2;
    localparam int unsigned ChRegionWords = 16;

    localparam int unsigned AddrGlob    = 'h10;
    localparam int unsigned AddrLl      = 'h11;
    localparam int unsigned AddrUr      = 'h12;
    localparam int unsigned AddrSize    = 'h13;
    localparam int unsigned AddrFilter  = 'h14;
    localparam int unsigned AddrStatus  = 'h15;
    localparam int unsigned AddrIrqMask = 'h16;
    localparam int unsigned AddrCommit  = 'h17;

    localparam int unsigned StatSof        = 0;
    localparam int unsigned StatEof        = 1;
    localparam int unsigned StatOvf        = 2;
    localparam int unsigned StatCommitDone = 3;
    localparam int unsigned StatCommitErr  = 4;
    localparam int unsigned NumStat        = 5;

    typedef enum logic [0:0] {StIdle, StPend} commit_state_e;

    typedef struct packed {
        logic [31:0] glob;
        logic [31:0] ll;
        logic [31:0] ur;
        logic [31:0] size;
        logic [31:0] filter;
    } cam_cfg_t;

endpackage

// File: rtl/camera_reg_if_mc_if.sv
// uDMA configuration bus: master drives the access, slave returns read data combinationally.
interface camera_reg_if_mc_if #(
    parameter int unsigned ADDR_W = 6
);
    logic [31:0]       wdata;
    logic [ADDR_W-1:0] addr;
    logic              valid;
    logic              rwn;
    logic [31:0]       rdata;
    logic              ready;

    modport master (output wdata, addr, valid, rwn, input rdata, ready);
    modport slave (input wdata, addr, valid, rwn, output rdata, ready);
endinterface

// File: rtl/camera_rx_ch_regs.sv
// One RX channel descriptor: start address, size, datasize/continuous and en/clr pulses.
module camera_rx_ch_regs
    import camera_reg_pkg::*;
#(
    parameter int unsigned L2_AWIDTH_NOAL = 12,
    parameter int unsigned TRANS_SIZE     = 16
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  logic                      sel,
    input  logic                      we,
    input  logic [1:0]                word,
    input  logic [31:0]               wdata,
    output logic [31:0]               rdata,
    input  logic [L2_AWIDTH_NOAL-1:0] curr_addr,
    input  logic [TRANS_SIZE-1:0]     bytes_left,
    input  logic                      en_stat,
    input  logic                      pending,
    output logic [L2_AWIDTH_NOAL-1:0] startaddr,
    output logic [TRANS_SIZE-1:0]     size,
    output logic [1:0]                datasize,
    output logic                      continuous,
    output logic                      en,
    output logic                      clr
);
    logic [L2_AWIDTH_NOAL-1:0] startaddr_q;
    logic [TRANS_SIZE-1:0]     size_q;
    logic [1:0]                datasize_q;
    logic                      continuous_q, en_q, clr_q;
    logic                      wr_saddr, wr_size, wr_cfg;
    logic                      unused_wdata;

    assign wr_saddr     = sel & we & (word == 2'(ChWordSaddr));
    assign wr_size      = sel & we & (word == 2'(ChWordSize));
    assign wr_cfg       = sel & we & (word == 2'(ChWordCfg));
    assign unused_wdata = ^wdata;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            startaddr_q  <= '0;
            size_q       <= '0;
            datasize_q   <= '0;
            continuous_q <= 1'b0;
            en_q         <= 1'b0;
            clr_q        <= 1'b0;
        end else begin
            en_q  <= wr_cfg & wdata[4];
            clr_q <= wr_cfg & wdata[6];
            if (wr_saddr) startaddr_q <= wdata[L2_AWIDTH_NOAL-1:0];
            if (wr_size) size_q <= wdata[TRANS_SIZE-1:0];
            if (wr_cfg) begin
                datasize_q   <= wdata[2:1];
                continuous_q <= wdata[0];
            end
        end
    end

    always_comb begin
        rdata = '0;
        if (sel) begin
            case (word)
                2'(ChWordSaddr): rdata = 32'(curr_addr);
                2'(ChWordSize):  rdata = 32'(bytes_left);
                2'(ChWordCfg):   rdata = {26'h0, pending, en_stat, 1'b0, datasize_q, continuous_q};
                default:         rdata = '0;
            endcase
        end
    end

    assign startaddr  = startaddr_q;
    assign size       = size_q;
    assign datasize   = datasize_q;
    assign continuous = continuous_q;
    assign en         = en_q;
    assign clr        = clr_q;
endmodule

// File: rtl/camera_reg_if_mc.sv
// Camera uDMA register bank: N_CH RX descriptors, staged/active camera config, W1C status, irq.
// Define CAMERA_REG_IF_ROI_CHECK_EN to reject commits whose LL corner lies beyond UR.
module camera_reg_if_mc
    import camera_reg_pkg::*;
#(
    parameter int unsigned L2_AWIDTH_NOAL = 12,
    parameter int unsigned TRANS_SIZE     = 16,
    parameter int unsigned N_CH           = 2,
    parameter int unsigned ADDR_W         = 6
) (
    input  logic                           clk_i,
    input  logic                           rstn_i,
    camera_reg_if_mc_if.slave              cfg,
    output logic [N_CH*L2_AWIDTH_NOAL-1:0] cfg_rx_startaddr_o,
    output logic [N_CH*TRANS_SIZE-1:0]     cfg_rx_size_o,
    output logic [N_CH*2-1:0]              cfg_rx_datasize_o,
    output logic [N_CH-1:0]                cfg_rx_continuous_o,
    output logic [N_CH-1:0]                cfg_rx_en_o,
    output logic [N_CH-1:0]                cfg_rx_clr_o,
    input  logic [N_CH-1:0]                cfg_rx_en_i,
    input  logic [N_CH-1:0]                cfg_rx_pending_i,
    input  logic [N_CH*L2_AWIDTH_NOAL-1:0] cfg_rx_curr_addr_i,
    input  logic [N_CH*TRANS_SIZE-1:0]     cfg_rx_bytes_left_i,
    input  logic                           cam_ip_en_i,
    input  logic                           cam_sof_i,
    input  logic                           cam_eof_i,
    input  logic                           cam_ovf_i,
    output logic [31:0]                    cfg_cam_cfg_o,
    output logic [31:0]                    cfg_cam_cfg_ll_o,
    output logic [31:0]                    cfg_cam_cfg_ur_o,
    output logic [31:0]                    cfg_cam_cfg_size_o,
    output logic [31:0]                    cfg_cam_cfg_filter_o,
    output logic                           irq_o
);
    logic [ADDR_W-1:0]  addr;
    logic [31:0]        addr_ext, rdata;
    logic               wr, commit_wr, commit_fire, roi_ok, irq_q;
    logic [N_CH-1:0]    ch_sel;
    logic [31:0]        ch_rdata [N_CH];
    cam_cfg_t           staging_q, active_q;
    commit_state_e      state_q;
    logic [NumStat-1:0] status_q, status_d, status_set, status_clr, mask_q;

    assign addr     = cfg.addr;
    assign addr_ext = 32'(addr);
    assign wr       = cfg.valid & ~cfg.rwn;

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        assign ch_sel[c] = (addr_ext < ChRegionWords) && (addr_ext[3:2] == 2'(c));

        camera_rx_ch_regs #(
            .L2_AWIDTH_NOAL(L2_AWIDTH_NOAL),
            .TRANS_SIZE    (TRANS_SIZE)
        ) u_ch (
            .clk_i     (clk_i),
            .rstn_i    (rstn_i),
            .sel       (ch_sel[c]),
            .we        (wr),
            .word      (addr_ext[1:0]),
            .wdata     (cfg.wdata),
            .rdata     (ch_rdata[c]),
            .curr_addr (cfg_rx_curr_addr_i[c*L2_AWIDTH_NOAL +: L2_AWIDTH_NOAL]),
            .bytes_left(cfg_rx_bytes_left_i[c*TRANS_SIZE +: TRANS_SIZE]),
            .en_stat   (cfg_rx_en_i[c]),
            .pending   (cfg_rx_pending_i[c]),
            .startaddr (cfg_rx_startaddr_o[c*L2_AWIDTH_NOAL +: L2_AWIDTH_NOAL]),
            .size      (cfg_rx_size_o[c*TRANS_SIZE +: TRANS_SIZE]),
            .datasize  (cfg_rx_datasize_o[c*2 +: 2]),
            .continuous(cfg_rx_continuous_o[c]),
            .en        (cfg_rx_en_o[c]),
            .clr       (cfg_rx_clr_o[c])
        );
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            staging_q <= '0;
            mask_q    <= '0;
        end else if (wr) begin
            case (addr_ext)
                AddrGlob:    staging_q.glob   <= cfg.wdata;
                AddrLl:      staging_q.ll     <= cfg.wdata;
                AddrUr:      staging_q.ur     <= cfg.wdata;
                AddrSize:    staging_q.size   <= cfg.wdata;
                AddrFilter:  staging_q.filter <= cfg.wdata;
                AddrIrqMask: mask_q           <= cfg.wdata[NumStat-1:0];
                default: ;
            endcase
        end
    end

    assign commit_wr   = wr && (addr_ext == AddrCommit) && cfg.wdata[0];
    assign commit_fire = (state_q == StPend) && (cam_sof_i || !cam_ip_en_i);

`ifdef CAMERA_REG_IF_ROI_CHECK_EN
    assign roi_ok = (staging_q.ll[15:0] <= staging_q.ur[15:0]) &&
                    (staging_q.ll[31:16] <= staging_q.ur[31:16]);
`else
    assign roi_ok = 1'b1;
`endif

    // The copy reads staging_q, so a staging write in the commit cycle lands after the copy.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q  <= StIdle;
            active_q <= '0;
        end else begin
            case (state_q)
                StIdle: if (commit_wr) state_q <= StPend;
                StPend: begin
                    if (commit_fire) begin
                        if (roi_ok) active_q <= staging_q;
                        if (!commit_wr) state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        status_set                 = '0;
        status_set[StatSof]        = cam_sof_i;
        status_set[StatEof]        = cam_eof_i;
        status_set[StatOvf]        = cam_ovf_i;
        status_set[StatCommitDone] = commit_fire & roi_ok;
        status_set[StatCommitErr]  = commit_fire & ~roi_ok;
        status_clr = (wr && addr_ext == AddrStatus) ? cfg.wdata[NumStat-1:0] : '0;
        status_d   = (status_q & ~status_clr) | status_set;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            status_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            status_q <= status_d;
            irq_q    <= |(status_d & mask_q);
        end
    end

    always_comb begin
        rdata = '0;
        for (int c = 0; c < N_CH; c++) rdata |= ch_rdata[c];
        case (addr_ext)
            AddrGlob:    rdata = {cam_ip_en_i, staging_q.glob[30:0]};
            AddrLl:      rdata = staging_q.ll;
            AddrUr:      rdata = staging_q.ur;
            AddrSize:    rdata = staging_q.size;
            AddrFilter:  rdata = staging_q.filter;
            AddrStatus:  rdata = 32'(status_q);
            AddrIrqMask: rdata = 32'(mask_q);
            AddrCommit:  rdata = {31'h0, state_q == StPend};
            default: ;
        endcase
    end

    assign cfg.rdata            = rdata;
    assign cfg.ready            = 1'b1;
    assign cfg_cam_cfg_o        = active_q.glob;
    assign cfg_cam_cfg_ll_o     = active_q.ll;
    assign cfg_cam_cfg_ur_o     = active_q.ur;
    assign cfg_cam_cfg_size_o   = active_q.size;
    assign cfg_cam_cfg_filter_o = active_q.filter;
    assign irq_o                = irq_q;
endmodule

// File: tb/tb_camera_reg_if_mc.sv
// Directed plus randomized bench for camera_reg_if_mc against a register-map level model.
module tb_camera_reg_if_mc;
    localparam int AW = 12, TW = 16, NCH = 2, ADDR_W = 6;
    localparam int CAW = NCH * AW, CTW = NCH * TW;

    logic clk = 1'b0, rstn = 1'b0;
    always #5 clk = ~clk;

    camera_reg_if_mc_if #(.ADDR_W(ADDR_W)) cfg_bus ();

    logic [CAW-1:0]   rx_saddr, curr_addr;
    logic [CTW-1:0]   rx_size, bytes_left;
    logic [NCH*2-1:0] rx_ds;
    logic [NCH-1:0]   rx_cont, rx_en_o, rx_clr_o, rx_en_i, rx_pend_i;
    logic             ip_en, sof, eof, ovf, irq;
    logic [31:0]      cam_cfg, cam_ll, cam_ur, cam_size, cam_filter;

    camera_reg_if_mc #(
        .L2_AWIDTH_NOAL(AW), .TRANS_SIZE(TW), .N_CH(NCH), .ADDR_W(ADDR_W)
    ) dut (
        .clk_i               (clk),
        .rstn_i              (rstn),
        .cfg                 (cfg_bus),
        .cfg_rx_startaddr_o  (rx_saddr),
        .cfg_rx_size_o       (rx_size),
        .cfg_rx_datasize_o   (rx_ds),
        .cfg_rx_continuous_o (rx_cont),
        .cfg_rx_en_o         (rx_en_o),
        .cfg_rx_clr_o        (rx_clr_o),
        .cfg_rx_en_i         (rx_en_i),
        .cfg_rx_pending_i    (rx_pend_i),
        .cfg_rx_curr_addr_i  (curr_addr),
        .cfg_rx_bytes_left_i (bytes_left),
        .cam_ip_en_i         (ip_en),
        .cam_sof_i           (sof),
        .cam_eof_i           (eof),
        .cam_ovf_i           (ovf),
        .cfg_cam_cfg_o       (cam_cfg),
        .cfg_cam_cfg_ll_o    (cam_ll),
        .cfg_cam_cfg_ur_o    (cam_ur),
        .cfg_cam_cfg_size_o  (cam_size),
        .cfg_cam_cfg_filter_o(cam_filter),
        .irq_o               (irq)
    );

    // Reference model state, named after the register map
    logic [AW-1:0] m_saddr [NCH];
    logic [TW-1:0] m_size  [NCH];
    logic [1:0]    m_ds    [NCH];
    logic          m_cont  [NCH];
    logic          m_en    [NCH];
    logic          m_clr   [NCH];
    logic [31:0]   m_stg   [5];
    logic [31:0]   m_act   [5];
    logic [4:0]    m_status, m_mask;
    logic          m_pend, m_irq;
    logic [31:0]   last_rdata;
    int            n_checks = 0, n_pass = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic bit roi_ok();
`ifdef CAMERA_REG_IF_ROI_CHECK_EN
        return (m_stg[1][15:0] <= m_stg[2][15:0]) && (m_stg[1][31:16] <= m_stg[2][31:16]);
`else
        return 1'b1;
`endif
    endfunction

    function automatic logic [31:0] model_read(input int a);
        logic [31:0] v;
        int c = a / 4;
        if (a < 16) begin
            if (c >= NCH) return 32'h0;
            case (a % 4)
                0: return 32'(curr_addr[c*AW +: AW]);
                1: return 32'(bytes_left[c*TW +: TW]);
                2: return {26'h0, rx_pend_i[c], rx_en_i[c], 1'b0, m_ds[c], m_cont[c]};
                default: return 32'h0;
            endcase
        end
        if (a >= 16 && a <= 20) begin
            v = m_stg[a-16];
            if (a == 16) v[31] = ip_en;
            return v;
        end
        if (a == 21) return 32'(m_status);
        if (a == 22) return 32'(m_mask);
        if (a == 23) return 32'(m_pend);
        return 32'h0;
    endfunction

    task automatic model_step();
        bit          wr = cfg_bus.valid && !cfg_bus.rwn;
        int          a = int'(cfg_bus.addr);
        logic [31:0] d = cfg_bus.wdata;
        logic [4:0]  set = {2'b00, ovf, eof, sof};
        logic [4:0]  clr = 5'h0;
        logic [4:0]  mask_old = m_mask;
        bit          fire = m_pend && (sof || !ip_en);
        for (int c = 0; c < NCH; c++) begin
            m_en[c]  = 1'b0;
            m_clr[c] = 1'b0;
        end
        if (fire) begin
            m_pend = 1'b0;
            if (roi_ok()) begin
                for (int i = 0; i < 5; i++) m_act[i] = m_stg[i];
                set[3] = 1'b1;
            end else begin
                set[4] = 1'b1;
            end
        end
        if (wr) begin
            if (a < 16 && a / 4 < NCH) begin
                case (a % 4)
                    0: m_saddr[a/4] = d[AW-1:0];
                    1: m_size[a/4] = d[TW-1:0];
                    2: begin
                        m_en[a/4]   = d[4];
                        m_clr[a/4]  = d[6];
                        m_ds[a/4]   = d[2:1];
                        m_cont[a/4] = d[0];
                    end
                    default: ;
                endcase
            end else if (a >= 16 && a <= 20) m_stg[a-16] = d;
            else if (a == 21) clr = d[4:0];
            else if (a == 22) m_mask = d[4:0];
            else if (a == 23 && d[0]) m_pend = 1'b1;
        end
        m_status = (m_status & ~clr) | set;
        m_irq    = |(m_status & mask_old);
    endtask

    task automatic compare_all();
        for (int c = 0; c < NCH; c++) begin
            check_eq("rx_saddr", rx_saddr[c*AW +: AW], m_saddr[c]);
            check_eq("rx_size", rx_size[c*TW +: TW], m_size[c]);
            check_eq("rx_datasize", rx_ds[c*2 +: 2], m_ds[c]);
            check_eq("rx_cont", rx_cont[c], m_cont[c]);
            check_eq("rx_en_pulse", rx_en_o[c], m_en[c]);
            check_eq("rx_clr_pulse", rx_clr_o[c], m_clr[c]);
        end
        check_eq("cam_cfg", cam_cfg, m_act[0]);
        check_eq("cam_ll", cam_ll, m_act[1]);
        check_eq("cam_ur", cam_ur, m_act[2]);
        check_eq("cam_size", cam_size, m_act[3]);
        check_eq("cam_filter", cam_filter, m_act[4]);
        check_eq("irq", irq, m_irq);
    endtask

    task automatic tick();
        @(negedge clk);
        last_rdata = cfg_bus.rdata;
        if (cfg_bus.valid && cfg_bus.rwn)
            check_eq("rdata", cfg_bus.rdata, model_read(int'(cfg_bus.addr)));
        check_eq("ready", cfg_bus.ready, 1'b1);
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic drive(input bit v, input bit rwn, input int a, input logic [31:0] d);
        cfg_bus.valid = v;
        cfg_bus.rwn   = rwn;
        cfg_bus.addr  = ADDR_W'(a);
        cfg_bus.wdata = d;
    endtask

    task automatic wr(input int a, input logic [31:0] d);
        drive(1'b1, 1'b0, a, d);
        tick();
        drive(1'b0, 1'b1, 0, 32'h0);
    endtask

    task automatic rd_chk(input string tag, input int a, input logic [31:0] exp);
        drive(1'b1, 1'b1, a, 32'h0);
        tick();
        check_eq(tag, last_rdata, exp);
        drive(1'b0, 1'b1, 0, 32'h0);
    endtask

    initial begin
        for (int c = 0; c < NCH; c++) begin
            m_saddr[c] = '0; m_size[c] = '0; m_ds[c] = '0;
            m_cont[c] = 1'b0; m_en[c] = 1'b0; m_clr[c] = 1'b0;
        end
        for (int i = 0; i < 5; i++) begin
            m_stg[i] = '0;
            m_act[i] = '0;
        end
        m_status = '0; m_mask = '0; m_pend = 1'b0; m_irq = 1'b0;
        drive(1'b0, 1'b1, 0, 32'h0);
        {rx_en_i, rx_pend_i, curr_addr, bytes_left} = '0;
        {ip_en, sof, eof, ovf} = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        check_eq("rst_irq", irq, 1'b0);
        rstn = 1'b1;
        rd_chk("rst_status", 'h15, 32'h0);
        rd_chk("rst_commit", 'h17, 32'h0);

        // Channel 1 CFG write pulses en/clr for one cycle
        wr(6, 32'h57);
        check_eq("ch1_en_pulse", rx_en_o[1], 1'b1);
        check_eq("ch1_clr_pulse", rx_clr_o[1], 1'b1);
        check_eq("ch1_datasize", rx_ds[3:2], 2'b11);
        check_eq("ch1_cont", rx_cont[1], 1'b1);
        check_eq("ch0_datasize", rx_ds[1:0], 2'b00);
        tick();
        check_eq("ch1_en_off", rx_en_o[1], 1'b0);
        check_eq("ch1_clr_off", rx_clr_o[1], 1'b0);

        // Commit waits for start of frame while the camera runs
        ip_en = 1'b1;
        wr('h11, 32'h0010_0010);
        wr('h12, 32'h0020_0020);
        wr('h17, 32'h1);
        repeat (3) tick();
        check_eq("ll_before_sof", cam_ll, 32'h0);
        rd_chk("commit_pending", 'h17, 32'h1);
        sof = 1'b1;
        tick();
        sof = 1'b0;
        check_eq("ll_after_sof", cam_ll, 32'h0010_0010);
        check_eq("ur_after_sof", cam_ur, 32'h0020_0020);
        rd_chk("status_sof_done", 'h15, 32'h09);
        rd_chk("commit_cleared", 'h17, 32'h0);
        wr('h15, 32'h1F);

        // Masked overflow interrupt, set beats clear
        wr('h16, 32'h4);
        ovf = 1'b1;
        tick();
        ovf = 1'b0;
        check_eq("irq_ovf", irq, 1'b1);
        drive(1'b1, 1'b0, 'h15, 32'h4);
        ovf = 1'b1;
        tick();
        ovf = 1'b0;
        drive(1'b0, 1'b1, 0, 32'h0);
        check_eq("irq_set_wins", irq, 1'b1);
        rd_chk("status_set_wins", 'h15, 32'h4);
        wr('h15, 32'h4);
        check_eq("irq_cleared", irq, 1'b0);

        // Idle camera: copy happens the cycle after COMMIT, using pre-write staging
        ip_en = 1'b0;
        wr('h13, 32'h0000_AAAA);
        wr('h17, 32'h1);
        wr('h13, 32'h0000_BBBB);
        check_eq("size_old_staging", cam_size, 32'h0000_AAAA);
        rd_chk("size_staging_new", 'h13, 32'h0000_BBBB);
        wr('h15, 32'h1F);

        // Inverted ROI corners
        wr('h11, 32'h0030_0030);
        wr('h12, 32'h0020_0020);
        wr('h17, 32'h1);
        tick();
`ifdef CAMERA_REG_IF_ROI_CHECK_EN
        check_eq("roi_ll_kept", cam_ll, 32'h0010_0010);
        rd_chk("roi_status_err", 'h15, 32'h10);
`else
        check_eq("roi_ll_copied", cam_ll, 32'h0030_0030);
        rd_chk("roi_status_done", 'h15, 32'h08);
`endif
        wr('h15, 32'h1F);

        // Channel index N_CH, reserved word and unmapped globals
        wr(8, 32'hFFFF_FFFF);
        wr(10, 32'hFFFF_FFFF);
        rd_chk("ch2_saddr_rd", 8, 32'h0);
        rd_chk("ch2_cfg_rd", 10, 32'h0);
        rd_chk("reserved_rd", 3, 32'h0);
        rd_chk("unmapped_rd", 'h20, 32'h0);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            cfg_bus.valid = ($urandom_range(0, 3) != 0);
            cfg_bus.rwn   = 1'($urandom_range(0, 1));
            cfg_bus.addr  = ($urandom_range(0, 7) == 0) ? ADDR_W'($urandom_range(0, 63))
                                                         : ADDR_W'($urandom_range(0, 23));
            cfg_bus.wdata = $urandom;
            sof = ($urandom_range(0, 9) == 0);
            eof = ($urandom_range(0, 9) == 0);
            ovf = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 19) == 0) ip_en = ~ip_en;
            rx_en_i    = NCH'($urandom);
            rx_pend_i  = NCH'($urandom);
            curr_addr  = CAW'($urandom);
            bytes_left = CTW'($urandom);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
